ptw_walker: RTL and testbench
=============================

# ptw_walker

Hardware page-table walker that serves TLB misses. It is the responder on the TLB's PTW interface. It accepts a one-cycle walk request carrying a 32-bit virtual address and performs a two-level (10/10/12) table walk through a single-outstanding memory read port. It returns either a 4 KiB leaf PTE in the TLB's format (PPN in [31:12], W/R/X perms in [2:0]) or a fault. It sits between the TLB and the memory/cache read port.

## Interface
- MEM_TIMEOUT, 64: max cycles per level spent in REQ+WAIT before a fault is forced; 0 disables the timeout.
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ptw_req_i  in  1  walk request pulse; accepted only in IDLE
- ptw_vaddr_i  in  32  virtual address; sampled with ptw_req_i
- root_ppn_i  in  20  root page-table PPN; sampled with ptw_req_i
- ptw_resp_valid_o  out  1  one-cycle response pulse
- ptw_pte_o  out  32  returned PTE; 0 on fault; held until next response
- ptw_fault_o  out  1  fault flag, qualified by ptw_resp_valid_o; held with ptw_pte_o
- busy_o  out  1  high in every state except IDLE
- mem_req_o  out  1  memory read request; held until mem_ready_i
- mem_addr_o  out  32  word-aligned read address; stable while mem_req_o=1
- mem_ready_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i

## Operation
- PTE format: [31:12] PPN, [3] V, [2] W, [1] R, [0] X. perms==3'b000 marks a pointer; any nonzero value marks a leaf.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP, DRAIN.
- IDLE: when ptw_req_i=1, latch vaddr and root_ppn, then go to L1_REQ. Requests arriving while busy_o=1 are ignored.
- L1_REQ: mem_addr_o={root_ppn, vaddr[31:22], 2'b00}. On mem_ready_i, go to L1_WAIT.
- L1_WAIT: on mem_rvalid_i, evaluate mem_rdata_i (call it pte):
  - mem_err_i, V=0, or W=1&R=0 → fault.
  - Pointer: latch pte[31:12], go to L0_REQ.
  - Leaf with pte[21:12]!=0 (misaligned superpage) → fault.
  - Leaf, aligned: return the 4 KiB splinter {pte[31:22], vaddr[21:12], pte[11:0]}.
- L0_REQ: mem_addr_o={l1_ppn, vaddr[21:12], 2'b00}. On mem_ready_i, go to L0_WAIT.
- L0_WAIT: on mem_rvalid_i:
  - mem_err_i, V=0, W=1&R=0, or pointer (perms==0) → fault.
  - Otherwise return pte unchanged.
- RESP: ptw_resp_valid_o=1 for exactly one cycle. Next state is DRAIN if a timed-out read is outstanding, else IDLE.
- Timeout counter, width $clog2(MEM_TIMEOUT+1):
  - Cleared on entry to L1_REQ/L0_REQ; increments each cycle in REQ/WAIT.
  - If it equals MEM_TIMEOUT-1 and the state is not advancing this cycle → RESP with fault.
  - A timeout in REQ drops mem_req_o with nothing outstanding.
  - A timeout in WAIT marks the read outstanding.
- DRAIN: wait for mem_rvalid_i and discard the data, then go to IDLE. The memory side guarantees one response per accepted request.
- mem_rvalid_i is sampled only in WAIT states and DRAIN. It is ignored elsewhere, including the cycle mem_ready_i is seen.

## Timing
- Reset values: state=IDLE, ptw_resp_valid_o=0, ptw_pte_o=0, ptw_fault_o=0, busy_o=0, mem_req_o=0, mem_addr_o=0.
- Reset asserted mid-walk: mem_req_o drops asynchronously and no response is produced. After release the block is in IDLE, and any stale rvalid is ignored in IDLE.
- All outputs are registered. busy_o rises the cycle after acceptance.
- Cycle counts below are measured from the accept edge at cycle 0, with ready and rvalid each arriving in the first cycle they are sampled:
  - two-level walk: resp at cycle 5
  - L1 leaf or L1 fault: resp at cycle 3
  - each extra wait cycle adds 1
- Earliest next accept: the cycle after RESP, when busy_o=0.

## Test plan
- Two-level walk: root_ppn=0x00010, vaddr=0x00403ABC; L1 read at 0x00010004 returns 0x00020008; L0 read at 0x0002000C returns 0x1234500B → resp at cycle 5, pte=0x1234500B, fault=0.
- Superpage: same vaddr, L1 returns 0x0C80000E → resp at cycle 3, pte=0x0C80300E, no L0 request issued.
- Faults:
  - L1 returns 0x00000000 → fault at cycle 3.
  - L1 returns 0x0C80100E (misaligned superpage) → fault at cycle 3.
  - L0 returns 0x1234500C (W without R) → fault at cycle 5.
  - In every case pte=0 and there are no further mem requests.
- mem_err_i=1 with L0 rvalid → fault=1, pte=0, resp at cycle 5; a ptw_req_i pulsed during the walk is ignored.
- MEM_TIMEOUT=8:
  - mem_ready_i held 0 → fault resp at cycle 9, mem_req_o low from cycle 9.
  - Ready given but rvalid withheld → fault, busy_o stays 1 in DRAIN until a late rvalid, then IDLE.
- rst_n pulsed low during L0_WAIT → all outputs go to 0 immediately; a new request afterwards walks correctly.

Source files
------------

// File: rtl/ptw_walker.sv
// Two-level (10/10/12) page-table walker answering TLB misses through a
// single-outstanding memory read port; returns a 4 KiB leaf PTE or a fault.
module ptw_walker #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ptw_req_i,
    input  logic [31:0] ptw_vaddr_i,
    input  logic [19:0] root_ppn_i,
    output logic        ptw_resp_valid_o,
    output logic [31:0] ptw_pte_o,
    output logic        ptw_fault_o,
    output logic        busy_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i
);

    localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_RESP, S_DRAIN
    } state_t;

    state_t      r_state;
    logic [9:0]  r_vpn0;
    logic [CW-1:0] r_cnt;
    logic        r_outstanding;

    logic        w_timeout;
    logic        w_bad;
    logic        w_ptr;
    logic        w_misaligned;
    logic        w_in_wait;
    logic        w_fin;
    logic        w_fin_fault;
    logic [31:0] w_fin_pte;
    logic        w_unused_vaddr;

    assign w_unused_vaddr = ^ptw_vaddr_i[11:0];

    assign w_timeout    = (MEM_TIMEOUT != 0) && (r_cnt == CW'(MEM_TIMEOUT - 1));
    assign w_bad        = mem_err_i | ~mem_rdata_i[3] | (mem_rdata_i[2] & ~mem_rdata_i[1]);
    assign w_ptr        = (mem_rdata_i[2:0] == 3'b000);
    assign w_misaligned = |mem_rdata_i[21:12];
    assign w_in_wait    = (r_state == S_L1_WAIT) || (r_state == S_L0_WAIT);

    // Decide whether the walk terminates this cycle, and with what result.
    always_comb begin
        w_fin       = 1'b0;
        w_fin_fault = 1'b0;
        w_fin_pte   = 32'h0;
        case (r_state)
            S_L1_REQ, S_L0_REQ: begin
                if (!mem_ready_i && w_timeout) begin
                    w_fin       = 1'b1;
                    w_fin_fault = 1'b1;
                end
            end
            S_L1_WAIT: begin
                if (mem_rvalid_i) begin
                    if (w_bad || (!w_ptr && w_misaligned)) begin
                        w_fin       = 1'b1;
                        w_fin_fault = 1'b1;
                    end else if (!w_ptr) begin
                        w_fin     = 1'b1;
                        w_fin_pte = {mem_rdata_i[31:22], r_vpn0, mem_rdata_i[11:0]};
                    end
                end else if (w_timeout) begin
                    w_fin       = 1'b1;
                    w_fin_fault = 1'b1;
                end
            end
            S_L0_WAIT: begin
                if (mem_rvalid_i) begin
                    w_fin = 1'b1;
                    if (w_bad || w_ptr) begin
                        w_fin_fault = 1'b1;
                    end else begin
                        w_fin_pte = mem_rdata_i;
                    end
                end else if (w_timeout) begin
                    w_fin       = 1'b1;
                    w_fin_fault = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= S_IDLE;
            r_vpn0           <= '0;
            r_cnt            <= '0;
            r_outstanding    <= 1'b0;
            ptw_resp_valid_o <= 1'b0;
            ptw_pte_o        <= 32'h0;
            ptw_fault_o      <= 1'b0;
            busy_o           <= 1'b0;
            mem_req_o        <= 1'b0;
            mem_addr_o       <= 32'h0;
        end else begin
            ptw_resp_valid_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ptw_req_i) begin
                        r_vpn0     <= ptw_vaddr_i[21:12];
                        mem_addr_o <= {root_ppn_i, ptw_vaddr_i[31:22], 2'b00};
                        mem_req_o  <= 1'b1;
                        r_cnt      <= '0;
                        busy_o     <= 1'b1;
                        r_state    <= S_L1_REQ;
                    end
                end
                S_L1_REQ, S_L0_REQ: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ready_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= (r_state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end
                S_L1_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_rvalid_i && !w_bad && w_ptr) begin
                        mem_addr_o <= {mem_rdata_i[31:12], r_vpn0, 2'b00};
                        mem_req_o  <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_L0_REQ;
                    end
                end
                S_L0_WAIT: r_cnt <= r_cnt + 1'b1;
                S_RESP: begin
                    busy_o  <= r_outstanding;
                    r_state <= r_outstanding ? S_DRAIN : S_IDLE;
                end
                S_DRAIN: begin
                    if (mem_rvalid_i) begin
                        r_outstanding <= 1'b0;
                        busy_o        <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A WAIT-state timeout leaves one read in flight that DRAIN must absorb.
            if (w_fin) begin
                ptw_resp_valid_o <= 1'b1;
                ptw_pte_o        <= w_fin_pte;
                ptw_fault_o      <= w_fin_fault;
                mem_req_o        <= 1'b0;
                r_outstanding    <= w_in_wait && !mem_rvalid_i;
                r_state          <= S_RESP;
            end
        end
    end

endmodule

// File: tb/tb_ptw_walker.sv
// Scoreboard bench for ptw_walker: directed walks with hand-computed PTEs,
// latencies and memory addresses; a monitor checks every response.
module tb_ptw_walker;

    logic        clk;
    logic        rst_n;
    logic        ptw_req_i;
    logic [31:0] ptw_vaddr_i;
    logic [19:0] root_ppn_i;
    logic        ptw_resp_valid_o;
    logic [31:0] ptw_pte_o;
    logic        ptw_fault_o;
    logic        busy_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;
    logic        mem_err_i = 1'b0;

    ptw_walker #(.MEM_TIMEOUT(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ptw_req_i        (ptw_req_i),
        .ptw_vaddr_i      (ptw_vaddr_i),
        .root_ppn_i       (root_ppn_i),
        .ptw_resp_valid_o (ptw_resp_valid_o),
        .ptw_pte_o        (ptw_pte_o),
        .ptw_fault_o      (ptw_fault_o),
        .busy_o           (busy_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_ready_i      (mem_ready_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i),
        .mem_err_i        (mem_err_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] pte;
        logic        fault;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] mem_tbl [logic [31:0]];

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;

    // Memory-side knobs
    logic        ready_en   = 1'b1;
    logic        hold_en    = 1'b0;
    logic [31:0] hold_addr  = 32'h0;
    logic        release_rv = 1'b0;
    logic        err_en     = 1'b0;
    logic [31:0] err_addr   = 32'h0;
    logic        held       = 1'b0;
    logic [31:0] held_addr  = 32'h0;
    logic [31:0] rd_addr    = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: ready the cycle after a request is seen, data the cycle after acceptance.
    always @(negedge clk) begin
        mem_rvalid_i = 1'b0;
        mem_err_i    = 1'b0;
        mem_rdata_i  = 32'h0;
        if (mem_ready_i) begin
            if (exp_addr_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_mem_req: got addr 0x%08h, expected no request", rd_addr);
            end else begin
                chk("mem_addr", rd_addr, exp_addr_q.pop_front());
            end
            $display("mem read accepted addr=0x%08h", rd_addr);
            if (hold_en && rd_addr == hold_addr) begin
                held      = 1'b1;
                held_addr = rd_addr;
            end else begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_tbl.exists(rd_addr) ? mem_tbl[rd_addr] : 32'h0;
                mem_err_i    = err_en && (rd_addr == err_addr);
            end
        end else if (held && release_rv) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = mem_tbl.exists(held_addr) ? mem_tbl[held_addr] : 32'h0;
            held         = 1'b0;
        end
        mem_ready_i = mem_req_o && ready_en && rst_n;
        rd_addr     = mem_addr_o;
    end

    // Response monitor
    always @(negedge clk) begin
        if (ptw_resp_valid_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_resp: got pte=0x%08h fault=%0b, expected no response",
                         ptw_pte_o, ptw_fault_o);
            end else begin
                exp_t e;
                int   lat;
                e   = exp_q.pop_front();
                lat = cyc - acc_cyc + 1;
                $display("resp %s: pte=0x%08h fault=%0b latency=%0d", e.name, ptw_pte_o, ptw_fault_o, lat);
                chk({e.name, "_pte"}, ptw_pte_o, e.pte);
                chk({e.name, "_fault"}, {31'h0, ptw_fault_o}, {31'h0, e.fault});
                chk({e.name, "_latency"}, lat, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] va, input logic [19:0] root);
        @(negedge clk);
        ptw_req_i   = 1'b1;
        ptw_vaddr_i = va;
        root_ppn_i  = root;
        @(posedge clk);
        #1;
        acc_cyc   = cyc;
        ptw_req_i = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] va, input logic [19:0] root,
                       input logic [31:0] epte, input logic efault, input int elat, input logic stray);
        exp_t e;
        int   n;
        e.name  = name;
        e.pte   = epte;
        e.fault = efault;
        e.lat   = elat;
        exp_q.push_back(e);
        issue(va, root);
        if (stray) begin
            @(negedge clk);
            @(negedge clk);
            ptw_req_i   = 1'b1;
            ptw_vaddr_i = 32'hFFC00000;
            @(negedge clk);
            ptw_req_i   = 1'b0;
        end
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s_no_resp: got no response in 60 cycles, expected one", name);
            exp_q.delete();
        end
        @(negedge clk);
        chk({name, "_mem_reqs_done"}, exp_addr_q.size(), 0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        ptw_req_i   = 1'b0;
        ptw_vaddr_i = 32'h0;
        root_ppn_i  = 20'h0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'h0, ptw_resp_valid_o}, 32'h0);
        chk("rst_pte", ptw_pte_o, 32'h0);
        chk("rst_fault", {31'h0, ptw_fault_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two-level walk
        mem_tbl[32'h00010004] = 32'h00020008;
        mem_tbl[32'h0002000C] = 32'h1234500B;
        exp_addr_q.push_back(32'h00010004);
        exp_addr_q.push_back(32'h0002000C);
        run("two_level", 32'h00403ABC, 20'h00010, 32'h1234500B, 1'b0, 5, 1'b0);
        chk("two_level_busy_after", {31'h0, busy_o}, 32'h0);

        // Aligned superpage splintered to 4 KiB
        mem_tbl[32'h00010004] = 32'h0C80000E;
        exp_addr_q.push_back(32'h00010004);
        run("superpage", 32'h00403ABC, 20'h00010, 32'h0C80300E, 1'b0, 3, 1'b0);

        // Invalid L1 entry
        mem_tbl[32'h00010004] = 32'h00000000;
        exp_addr_q.push_back(32'h00010004);
        run("l1_invalid", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 3, 1'b0);

        // Misaligned superpage
        mem_tbl[32'h00010004] = 32'h0C80100E;
        exp_addr_q.push_back(32'h00010004);
        run("misaligned", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 3, 1'b0);

        // L0 leaf with W but not R
        mem_tbl[32'h00010004] = 32'h00020008;
        mem_tbl[32'h0002000C] = 32'h1234500C;
        exp_addr_q.push_back(32'h00010004);
        exp_addr_q.push_back(32'h0002000C);
        run("l0_w_no_r", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 5, 1'b0);

        // Bus error on L0, with a stray request during the walk
        mem_tbl[32'h0002000C] = 32'h1234500B;
        err_en   = 1'b1;
        err_addr = 32'h0002000C;
        exp_addr_q.push_back(32'h00010004);
        exp_addr_q.push_back(32'h0002000C);
        run("l0_bus_err", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 5, 1'b1);
        err_en = 1'b0;
        chk("bus_err_busy_after", {31'h0, busy_o}, 32'h0);

        // Timeout with ready held low
        ready_en = 1'b0;
        run("timeout_ready", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 9, 1'b0);
        chk("timeout_ready_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("timeout_ready_busy", {31'h0, busy_o}, 32'h0);
        ready_en = 1'b1;

        // Timeout waiting for rvalid, then drain a late response
        mem_tbl[32'h00010004] = 32'h00020008;
        hold_en   = 1'b1;
        hold_addr = 32'h00010004;
        exp_addr_q.push_back(32'h00010004);
        run("timeout_rvalid", 32'h00403ABC, 20'h00010, 32'h0, 1'b1, 9, 1'b0);
        repeat (3) @(negedge clk);
        chk("drain_busy_held", {31'h0, busy_o}, 32'h1);
        chk("drain_no_mem_req", {31'h0, mem_req_o}, 32'h0);
        release_rv = 1'b1;
        n = 0;
        while (busy_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("drain_busy_released", {31'h0, busy_o}, 32'h0);
        release_rv = 1'b0;

        // Reset during L0_WAIT
        hold_addr = 32'h0002000C;
        exp_addr_q.push_back(32'h00010004);
        exp_addr_q.push_back(32'h0002000C);
        issue(32'h00403ABC, 20'h00010);
        n = 0;
        while (exp_addr_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rst_walk_reached_l0", exp_addr_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'h0, busy_o}, 32'h0);
        chk("midrst_mem_req", {31'h0, mem_req_o}, 32'h0);
        chk("midrst_mem_addr", mem_addr_o, 32'h0);
        chk("midrst_resp_valid", {31'h0, ptw_resp_valid_o}, 32'h0);
        chk("midrst_pte", ptw_pte_o, 32'h0);
        @(negedge clk);
        rst_n      = 1'b1;
        release_rv = 1'b1;
        repeat (4) @(negedge clk);
        chk("stale_rvalid_ignored_busy", {31'h0, busy_o}, 32'h0);
        release_rv = 1'b0;
        hold_en    = 1'b0;

        // Fresh walk after reset
        mem_tbl[32'h0001000C] = 32'h00020008;
        mem_tbl[32'h00020014] = 32'hABCDE00F;
        exp_addr_q.push_back(32'h0001000C);
        exp_addr_q.push_back(32'h00020014);
        run("post_reset_walk", 32'h00C05123, 20'h00010, 32'hABCDE00F, 1'b0, 5, 1'b0);

        repeat (3) @(negedge clk);
        chk("final_resp_q_empty", exp_q.size(), 0);
        chk("final_addr_q_empty", exp_addr_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
